// File: rtl/amo_sequencer.sv
// rtl/amo_sequencer.sv - RV64A LR/SC/AMO multi-cycle sequencer with LR/SC reservation
module amo_sequencer #(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 64,
    parameter int RSV_LG2 = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        funct5,
    input  logic              is_dword,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   src,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_dword,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              snoop_valid,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   result,
    output logic              misaligned,
    output logic              illegal,
    output logic              rsv_valid
);
    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;
    localparam int         RSV_W  = ADDR_W - RSV_LG2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    function automatic logic [XLEN-1:0] zext_w(input logic [XLEN-1:0] v);
        return {{(XLEN-32){1'b0}}, v[31:0]};
    endfunction

    function automatic logic is_legal(input logic [4:0] f);
        case (f)
            F_LR, F_SC, F_SWAP, F_ADD, F_XOR, F_AND, F_OR,
            F_MIN, F_MAX, F_MINU, F_MAXU: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    // .W compares are done on 32-bit values widened to XLEN so one comparator serves both sizes
    function automatic logic [XLEN-1:0] amo_modify(input logic [4:0] op, input logic dw,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        logic [XLEN-1:0] a_s, b_s, a_u, b_u, r;
        logic            lt_s, lt_u;
        a_s  = dw ? a : sext_w(a);
        b_s  = dw ? b : sext_w(b);
        a_u  = dw ? a : zext_w(a);
        b_u  = dw ? b : zext_w(b);
        lt_s = $signed(a_s) < $signed(b_s);
        lt_u = a_u < b_u;
        case (op)
            F_ADD:   r = a + b;
            F_XOR:   r = a ^ b;
            F_AND:   r = a & b;
            F_OR:    r = a | b;
            F_MIN:   r = lt_s ? a : b;
            F_MAX:   r = lt_s ? b : a;
            F_MINU:  r = lt_u ? a : b;
            F_MAXU:  r = lt_u ? b : a;
            default: r = b;
        endcase
        return dw ? r : sext_w(r);
    endfunction

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_dword_q, mem_dword_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              misaligned_q, misaligned_d;
    logic              illegal_q, illegal_d;
    logic              rsv_valid_q, rsv_valid_d;
    logic [RSV_W-1:0]  rsv_addr_q, rsv_addr_d;
    logic [4:0]        op_q, op_d;
    logic [XLEN-1:0]   src_q, src_d;

    logic              snoop_hit;
    logic              sc_ok;
    logic              mis_chk;
    logic              ill_chk;
    logic [XLEN-1:0]   rdata_ext;

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_dword_d  = mem_dword_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        done_d       = 1'b0;
        result_d     = result_q;
        misaligned_d = misaligned_q;
        illegal_d    = illegal_q;
        rsv_valid_d  = rsv_valid_q;
        rsv_addr_d   = rsv_addr_q;
        op_d         = op_q;
        src_d        = src_q;

        snoop_hit = snoop_valid && rsv_valid_q && (snoop_addr[ADDR_W-1:RSV_LG2] == rsv_addr_q);
        sc_ok     = rsv_valid_q && (addr[ADDR_W-1:RSV_LG2] == rsv_addr_q) && !snoop_hit;
        mis_chk   = is_dword ? (addr[2:0] != 3'd0) : (addr[1:0] != 2'd0);
        ill_chk   = !is_legal(funct5);
        rdata_ext = mem_dword_q ? mem_rdata : sext_w(mem_rdata);

        if (snoop_hit) begin
            rsv_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d         = funct5;
                    src_d        = src;
                    mem_addr_d   = addr;
                    mem_dword_d  = is_dword;
                    misaligned_d = mis_chk;
                    illegal_d    = ill_chk;
                    if (funct5 == F_SC) begin
                        rsv_valid_d = 1'b0;
                    end
                    if (mis_chk || ill_chk) begin
                        state_d  = S_FIN;
                        done_d   = 1'b1;
                        result_d = '0;
                    end else if (funct5 == F_SC) begin
                        if (sc_ok) begin
                            state_d     = S_WRITE;
                            mem_req_d   = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = src;
                        end else begin
                            state_d  = S_FIN;
                            done_d   = 1'b1;
                            result_d = {{(XLEN-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_d   = S_READ;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                    end
                end
            end
            S_READ: begin
                if (mem_ack) begin
                    result_d = rdata_ext;
                    if (op_q == F_LR) begin
                        rsv_valid_d = 1'b1;
                        rsv_addr_d  = mem_addr_q[ADDR_W-1:RSV_LG2];
                        mem_req_d   = 1'b0;
                        state_d     = S_FIN;
                        done_d      = 1'b1;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = amo_modify(op_q, mem_dword_q, rdata_ext, src_q);
                        state_d     = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = S_FIN;
                    done_d    = 1'b1;
                    if (op_q == F_SC) begin
                        result_d = '0;
                    end
                end
            end
            default: begin
                state_d      = S_IDLE;
                misaligned_d = 1'b0;
                illegal_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_dword_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            done_q       <= 1'b0;
            result_q     <= '0;
            misaligned_q <= 1'b0;
            illegal_q    <= 1'b0;
            rsv_valid_q  <= 1'b0;
            rsv_addr_q   <= '0;
            op_q         <= '0;
            src_q        <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_dword_q  <= mem_dword_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            done_q       <= done_d;
            result_q     <= result_d;
            misaligned_q <= misaligned_d;
            illegal_q    <= illegal_d;
            rsv_valid_q  <= rsv_valid_d;
            rsv_addr_q   <= rsv_addr_d;
            op_q         <= op_d;
            src_q        <= src_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_dword  = mem_dword_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign done       = done_q;
    assign result     = result_q;
    assign misaligned = misaligned_q;
    assign illegal    = illegal_q;
    assign rsv_valid  = rsv_valid_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_amo_sequencer.sv
// tb/tb_amo_sequencer.sv - scoreboard bench with behavioural RV64A model for amo_sequencer
`timescale 1ns/1ps
module tb_amo_sequencer;
    localparam logic [4:0] LR = 5'b00010, SC = 5'b00011, SWAP = 5'b00001, ADD = 5'b00000;
    localparam logic [4:0] XOR_ = 5'b00100, AND_ = 5'b01100, OR_ = 5'b01000;
    localparam logic [4:0] MIN = 5'b10000, MAX = 5'b10100, MINU = 5'b11000, MAXU = 5'b11100;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, is_dword = 1'b0;
    logic [4:0]  funct5 = '0;
    logic [63:0] addr = '0, src = '0, mem_addr, mem_wdata, mem_rdata = '0, snoop_addr = '0, result;
    logic        mem_req, mem_we, mem_dword, mem_ack = 1'b0, snoop_valid = 1'b0;
    logic        busy, done, misaligned, illegal, rsv_valid;

    amo_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .funct5(funct5), .is_dword(is_dword),
        .addr(addr), .src(src), .mem_req(mem_req), .mem_we(mem_we), .mem_dword(mem_dword),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .busy(busy), .done(done),
        .result(result), .misaligned(misaligned), .illegal(illegal), .rsv_valid(rsv_valid)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] result; logic mis; logic ill; int lat; int t0; } resp_t;
    typedef struct { logic we; logic dw; logic [63:0] addr; logic [63:0] wdata; } beat_t;

    resp_t resp_q[$];
    beat_t beat_q[$];
    int checks = 0, failures = 0, cyc = 0;
    int read_wait = 0, rand_wait = 0, cur_wait = -1;
    bit write_hold = 1'b0;
    bit rsv_v = 1'b0;
    logic [63:0] rsv_a = '0;
    logic [31:0] model_mem [longint];
    logic [31:0] phys_mem [longint];
    logic [4:0] amo_ops [9] = '{SWAP, ADD, XOR_, AND_, OR_, MIN, MAX, MINU, MAXU};

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_init(input longint w);
        logic [31:0] lo;
        lo = w[31:0];
        return (lo * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] model_rd(input longint w);
        return model_mem.exists(w) ? model_mem[w] : mem_init(w);
    endfunction

    function automatic logic [31:0] phys_rd(input longint w);
        return phys_mem.exists(w) ? phys_mem[w] : mem_init(w);
    endfunction

    function automatic logic [63:0] model_read(input logic [63:0] a, input bit dw);
        longint w;
        logic [31:0] lo;
        w  = longint'(a >> 2);
        lo = model_rd(w);
        if (dw) return {model_rd(w + 1), lo};
        return {{32{lo[31]}}, lo};
    endfunction

    task automatic model_write(input logic [63:0] a, input bit dw, input logic [63:0] v);
        longint w;
        w = longint'(a >> 2);
        model_mem[w] = v[31:0];
        if (dw) model_mem[w + 1] = v[63:32];
    endtask

    task automatic preload(input logic [63:0] a, input logic [63:0] v);
        longint w;
        w = longint'(a >> 2);
        model_mem[w] = v[31:0]; model_mem[w + 1] = v[63:32];
        phys_mem[w]  = v[31:0]; phys_mem[w + 1]  = v[63:32];
    endtask

    function automatic bit legal(input logic [4:0] f);
        return f inside {LR, SC, SWAP, ADD, XOR_, AND_, OR_, MIN, MAX, MINU, MAXU};
    endfunction

    function automatic logic [63:0] ref_amo(input logic [4:0] f, input bit dw,
                                            input logic [63:0] o, input logic [63:0] s);
        longint sa = o, sb = s;
        longint unsigned ua = o, ub = s;
        int wa = o[31:0], wb = s[31:0];
        int unsigned uwa = o[31:0], uwb = s[31:0];
        bit lt_s, lt_u;
        lt_s = dw ? (sa < sb) : (wa < wb);
        lt_u = dw ? (ua < ub) : (uwa < uwb);
        case (f)
            ADD:     return o + s;
            XOR_:    return o ^ s;
            AND_:    return o & s;
            OR_:     return o | s;
            MIN:     return lt_s ? o : s;
            MAX:     return lt_s ? s : o;
            MINU:    return lt_u ? o : s;
            MAXU:    return lt_u ? s : o;
            default: return s;
        endcase
    endfunction

    task automatic model_snoop(input logic [63:0] sa);
        if (rsv_v && ((sa >> 3) == rsv_a)) rsv_v = 1'b0;
    endtask

    task automatic push_beat(input bit we, input bit dw, input logic [63:0] a, input logic [63:0] d);
        beat_t b;
        b.we = we; b.dw = dw; b.addr = a; b.wdata = d;
        beat_q.push_back(b);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // memory responder: plain array, writes come from the DUT beats
    initial forever begin
        longint w;
        @(negedge clk);
        mem_ack = 1'b0;
        if (mem_req && !rst && !(write_hold && mem_we)) begin
            if (cur_wait < 0)
                cur_wait = (rand_wait > 0) ? int'($urandom_range(rand_wait, 0)) : (mem_we ? 0 : read_wait);
            if (cur_wait == 0) begin
                mem_ack = 1'b1;
                w = longint'(mem_addr >> 2);
                if (mem_we) begin
                    phys_mem[w] = mem_wdata[31:0];
                    if (mem_dword) phys_mem[w + 1] = mem_wdata[63:32];
                end else begin
                    mem_rdata = {phys_rd(w + 1), phys_rd(w)};
                end
                cur_wait = -1;
            end else begin
                cur_wait--;
            end
        end else if (!mem_req) begin
            cur_wait = -1;
        end
    end

    // monitor / scoreboard
    initial begin
        bit prev_wait = 1'b0, prev_we = 1'b0, prev_dw = 1'b0;
        logic [63:0] prev_addr = '0;
        beat_t b;
        resp_t r;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_wait = 1'b0;
            end else begin
                if (prev_wait && mem_req) begin
                    check64("stable_addr", mem_addr, prev_addr);
                    check64("stable_we", mem_we, prev_we);
                    check64("stable_dword", mem_dword, prev_dw);
                end
                if (mem_req && beat_q.size() == 0) begin
                    check64("unexpected_mem_req", mem_req, 0);
                end else if (mem_req && mem_ack) begin
                    b = beat_q.pop_front();
                    check64("beat_we", mem_we, b.we);
                    check64("beat_addr", mem_addr, b.addr);
                    check64("beat_dword", mem_dword, b.dw);
                    if (b.we)
                        check64("beat_wdata", b.dw ? mem_wdata : {32'd0, mem_wdata[31:0]},
                                b.dw ? b.wdata : {32'd0, b.wdata[31:0]});
                end
                prev_wait = mem_req && !mem_ack;
                prev_addr = mem_addr; prev_we = mem_we; prev_dw = mem_dword;
                if (done) begin
                    if (resp_q.size() == 0) begin
                        check64("unexpected_done", done, 0);
                    end else begin
                        r = resp_q.pop_front();
                        check64("result", result, r.result);
                        check64("misaligned", misaligned, r.mis);
                        check64("illegal", illegal, r.ill);
                        if (r.lat >= 0) check64("latency", cyc - r.t0, r.lat);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 200 && busy; k++) @(negedge clk);
        if (busy) check64("idle_timeout", busy, 0);
    endtask

    task automatic do_op(input logic [4:0] f5, input bit dw, input logic [63:0] a,
                         input logic [63:0] s, input bit snp, input logic [63:0] sa);
        resp_t r;
        bit mis, ill, sc_ok;
        logic [63:0] old;
        wait_idle();
        if (snp) model_snoop(sa);
        mis = dw ? (a[2:0] != 3'd0) : (a[1:0] != 2'd0);
        ill = !legal(f5);
        sc_ok = rsv_v && (rsv_a == (a >> 3));
        if (f5 == SC) rsv_v = 1'b0;
        r.mis = mis; r.ill = ill; r.result = '0; r.lat = 1;
        if (!mis && !ill) begin
            if (f5 == SC) begin
                if (sc_ok) begin
                    push_beat(1'b1, dw, a, s);
                    model_write(a, dw, s);
                    r.lat = 2;
                end else begin
                    r.result = 64'd1;
                end
            end else begin
                old = model_read(a, dw);
                r.result = old;
                push_beat(1'b0, dw, a, '0);
                if (f5 == LR) begin
                    rsv_v = 1'b1; rsv_a = a >> 3; r.lat = 2;
                end else begin
                    push_beat(1'b1, dw, a, ref_amo(f5, dw, old, s));
                    model_write(a, dw, ref_amo(f5, dw, old, s));
                    r.lat = 3;
                end
            end
        end
        if (rand_wait > 0 || read_wait > 0) r.lat = -1;
        @(negedge clk);
        #1;
        r.t0 = cyc;
        resp_q.push_back(r);
        start = 1'b1; funct5 = f5; is_dword = dw; addr = a; src = s;
        if (snp) begin snoop_valid = 1'b1; snoop_addr = sa; end
        @(negedge clk);
        #1;
        start = 1'b0; snoop_valid = 1'b0; funct5 = 5'($urandom); addr = {$urandom, $urandom};
        for (int k = 0; k < 100 && resp_q.size() != 0; k++) begin
            @(negedge clk);
            #3;
        end
        if (resp_q.size() != 0) begin
            check64("done_timeout", resp_q.size(), 0);
            resp_q.delete();
            beat_q.delete();
        end
        check64("rsv_valid", rsv_valid, rsv_v);
    endtask

    task automatic do_snoop(input logic [63:0] sa);
        wait_idle();
        @(negedge clk);
        #1;
        snoop_valid = 1'b1; snoop_addr = sa;
        model_snoop(sa);
        @(negedge clk);
        #1;
        snoop_valid = 1'b0;
        check64("rsv_after_snoop", rsv_valid, rsv_v);
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] f5;
        logic [63:0] a, last_a, old;
        bit dw;
        int k;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        check64("reset_busy", busy, 0);
        check64("reset_mem_req", mem_req, 0);
        check64("reset_mem_we", mem_we, 0);
        check64("reset_done", done, 0);
        check64("reset_flags", {misaligned, illegal, rsv_valid}, 0);
        check64("reset_result", result, 0);
        check64("reset_mem_addr", mem_addr, 0);
        check64("reset_mem_wdata", mem_wdata, 0);

        preload(64'h1000, 64'h10);
        do_op(ADD, 1'b1, 64'h1000, 64'd5, 1'b0, '0);
        check64("amoadd_mem", {phys_rd(64'h401), phys_rd(64'h400)}, 64'h15);

        preload(64'h5000, 64'hFFFFFFFF);
        do_op(MIN, 1'b0, 64'h5000, 64'd1, 1'b0, '0);
        check64("amomin_w_mem", phys_rd(64'h1400), 32'hFFFFFFFF);
        preload(64'h5000, 64'hFFFFFFFF);
        do_op(MINU, 1'b0, 64'h5000, 64'd1, 1'b0, '0);
        check64("amominu_w_mem", phys_rd(64'h1400), 32'h1);

        do_op(LR, 1'b1, 64'h2000, '0, 1'b0, '0);
        do_op(SC, 1'b1, 64'h2000, 64'd7, 1'b0, '0);
        check64("sc_mem", {phys_rd(64'h801), phys_rd(64'h800)}, 64'd7);
        do_op(SC, 1'b1, 64'h2000, 64'd9, 1'b0, '0);

        do_op(LR, 1'b0, 64'h3000, '0, 1'b0, '0);
        do_snoop(64'h3004);
        do_op(SC, 1'b0, 64'h3000, 64'd3, 1'b0, '0);
        do_op(LR, 1'b0, 64'h3000, '0, 1'b0, '0);
        do_snoop(64'h3008);
        do_op(SC, 1'b0, 64'h3000, 64'd3, 1'b0, '0);
        do_op(LR, 1'b1, 64'h3000, '0, 1'b0, '0);
        do_op(SC, 1'b1, 64'h3000, 64'd4, 1'b1, 64'h3000);

        do_op(SWAP, 1'b0, 64'h1002, 64'd1, 1'b0, '0);
        do_op(5'b11111, 1'b1, 64'h1000, 64'd1, 1'b0, '0);

        // slow read beat, start while busy, then reset while the write beat is held
        wait_idle();
        read_wait = 3; write_hold = 1'b1;
        old = model_read(64'h4000, 1'b1);
        push_beat(1'b0, 1'b1, 64'h4000, '0);
        push_beat(1'b1, 1'b1, 64'h4000, old + 64'd2);
        @(negedge clk);
        #1;
        start = 1'b1; funct5 = ADD; is_dword = 1'b1; addr = 64'h4000; src = 64'd2;
        @(negedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        #1;
        start = 1'b1; funct5 = SWAP; addr = 64'h4100; src = 64'd99;
        @(negedge clk);
        #1;
        start = 1'b0;
        for (k = 0; k < 20 && !(mem_req && mem_we); k++) @(negedge clk);
        #1;
        check64("held_write_beat", {mem_req, mem_we}, 2'b11);
        check64("read_beat_consumed", beat_q.size(), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check64("rst_mem_req", mem_req, 0);
        check64("rst_busy", busy, 0);
        check64("rst_done", done, 0);
        beat_q.delete();
        rsv_v = 1'b0;
        write_hold = 1'b0; read_wait = 0;
        repeat (6) @(negedge clk);
        check64("rst_no_late_done", resp_q.size(), 0);

        last_a = 64'h8000;
        for (int i = 0; i < 300; i++) begin
            rand_wait = (i % 3 == 0) ? 2 : 0;
            k = int'($urandom_range(99, 0));
            dw = 1'($urandom);
            if (k < 25) f5 = LR;
            else if (k < 50) f5 = SC;
            else if (k < 95) f5 = amo_ops[$urandom_range(8, 0)];
            else f5 = 5'($urandom);
            a = 64'h8000 + (64'($urandom_range(15, 0)) << 3);
            if (f5 == SC && $urandom_range(9, 0) < 7) a = last_a;
            if (!dw && $urandom_range(1, 0) == 1) a[2] = 1'b1;
            if ($urandom_range(9, 0) == 0) a = a + 64'($urandom_range(3, 1));
            if (f5 == LR) last_a = a;
            if ($urandom_range(5, 0) == 0) do_snoop(64'h8000 + 64'($urandom_range(127, 0)));
            do_op(f5, dw, a, {$urandom, $urandom}, $urandom_range(7, 0) == 0,
                  64'h8000 + 64'($urandom_range(127, 0)));
        end
        rand_wait = 0;
        wait_idle();
        repeat (3) @(negedge clk);
        check64("final_beats_drained", beat_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/amo_sequencer.md
Name: amo_sequencer

Overview:
Multi-cycle sequencer for RV64A instructions: LR.W/D, SC.W/D, and the AMO*.W/D operations (AMO = atomic read-modify-write).
- Sits between execute and the data-memory port; stalls the pipeline while busy.
- Owns the single LR/SC reservation register.
- Issues the read and write beats of each AMO over a req/ack memory handshake and computes the modify step internally.

Parameters:
XLEN, 64, data width.
ADDR_W, 64, address width.
RSV_LG2, 3, log2 of the reservation granule in bytes.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
start  in  1  one-cycle request; sampled only in IDLE.
funct5  in  5  instruction[31:27]; selects the operation.
is_dword  in  1  1 = .D (funct3 011), 0 = .W (funct3 010).
addr  in  ADDR_W  rs1 value.
src  in  XLEN  rs2 value.
mem_req  out  1  memory request, held until mem_ack.
mem_we  out  1  1 = write beat.
mem_dword  out  1  access size, 1 = 8 bytes, 0 = 4 bytes.
mem_addr  out  ADDR_W  access address.
mem_wdata  out  XLEN  write data; .W data in bits [31:0].
mem_ack  in  1  completes the current beat.
mem_rdata  in  XLEN  read data, valid with mem_ack when mem_we=0.
snoop_valid  in  1  external or other-hart store observed.
snoop_addr  in  ADDR_W  address of that store.
busy  out  1  high in every non-IDLE state.
done  out  1  one-cycle completion pulse.
result  out  XLEN  rd writeback value, valid with done.
misaligned  out  1  with done: address misaligned, no access made.
illegal  out  1  with done: unsupported funct5, no access made.
rsv_valid  out  1  reservation held (debug).

Behaviour:
- Reset:
  - state=IDLE.
  - mem_req, mem_we, done, misaligned, illegal, busy, rsv_valid all 0.
  - result, mem_addr, mem_wdata all 0.
  - A reset during any beat drops mem_req on the next edge; the in-flight op is abandoned with no done pulse.
- States: IDLE, READ, WRITE, FIN.
- IDLE, on start:
  - latch all inputs;
  - misaligned = addr[1:0]!=0 for .W, addr[2:0]!=0 for .D;
  - illegal = funct5 not in {00010 LR, 00011 SC, 00001 SWAP, 00000 ADD, 00100 XOR, 01100 AND, 01000 OR, 10000 MIN, 10100 MAX, 11000 MINU, 11100 MAXU}.
- IDLE -> FIN when misaligned or illegal. Otherwise:
  - LR -> READ;
  - SC -> WRITE if the reservation matches, else FIN with result=1;
  - AMO -> READ.
- start is ignored while busy.
- READ:
  - mem_req=1, mem_we=0.
  - On mem_ack, latch old = mem_rdata; for .W, sign-extend bits [31:0] to XLEN.
  - LR: set rsv_valid=1 and rsv_addr = addr>>RSV_LG2, then -> FIN.
  - AMO: -> WRITE.
- WRITE:
  - mem_req=1, mem_we=1.
  - mem_wdata = src for SC and SWAP; otherwise f(old, src) with f one of ADD, XOR, AND, OR, MIN, MAX, MINU, MAXU.
  - For .W, f is computed on the low 32 bits with signed/unsigned compare at 32 bits; the upper wdata bits are don't-care.
  - On mem_ack -> FIN. SC sets result=0.
- FIN:
  - done=1 for exactly one cycle, then -> IDLE.
  - result: old for LR/AMO, 0/1 for SC, 0 on error.
- Reservation:
  - Any SC, pass or fail, clears rsv_valid when it leaves IDLE.
  - snoop_valid with snoop_addr>>RSV_LG2 == rsv_addr clears rsv_valid on the next edge.
  - A snoop in the same cycle as the SC evaluation in IDLE takes priority: the SC fails.
  - A new LR overwrites an existing reservation.
  - AMOs do not affect the reservation.
- mem_addr, mem_dword and mem_we stay stable while mem_req=1 and mem_ack=0. Back-pressure of any length is tolerated.
- Latency with zero-wait memory (start at T):
  - AMO: read beat T+1, write beat T+2, done T+3.
  - LR: done T+2.
  - SC pass: done T+2.
  - SC fail or error: done T+1.
- busy is combinational from state; done and result are registered.

Test Plan:
1. AMOADD.D: addr 0x1000, src 5, memory holds 0x10, zero-wait ack -> done at T+3, result 0x10, write beat wdata 0x15 to 0x1000.
2. AMOMIN.W vs AMOMINU.W: old 0xFFFFFFFF, src 1 -> MIN writes 0xFFFFFFFF, MINU writes 1; both return result 0xFFFFFFFFFFFFFFFF.
3. LR.D 0x2000, then SC.D 0x2000 src 7 -> SC result 0 with write beat 7. A second SC.D 0x2000 -> result 1, no mem_req.
4. LR.W 0x3000, snoop_valid with snoop_addr 0x3004, then SC.W 0x3000 -> result 1. Repeat with snoop 0x3008 -> result 0.
5. AMOSWAP.W at 0x1002 -> done at T+1, misaligned=1, mem_req never asserted. funct5 11111 -> illegal=1.
6. mem_ack delayed 3 cycles on the read beat, start pulsed while busy, then rst during the write beat -> outputs stable while waiting, the extra start is ignored, and mem_req=0 with no done after the reset edge.
